dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Multi-cycle data-memory responder serving the MEM stage's load/store requests.
//   The MEM stage is the initiator; this block holds the data array and answers after
//   a fixed latency. It drives a stall that freezes the pipeline until the response.
//   It sits where the single-cycle data memory sits, between EXE2MEM and MEM2WB.
// PARAMETERS
//   WORD_LEN   32    data/address width in bits
//   DEPTH      64    number of words in the array
//   BASE_ADDR  1024  byte address of word 0
//   LATENCY    2     cycles from acceptance to done; legal range 1..15
// PORTS
//   clk        in   1         single clock, rising edge
//   rst        in   1         asynchronous, active-low reset
//   mem_r_en   in   1         load request (MEM_R_EN from EXE2MEM)
//   mem_w_en   in   1         store request (MEM_W_EN from EXE2MEM)
//   addr       in   WORD_LEN  byte address (ALU result)
//   wdata      in   WORD_LEN  store data
//   rdata      out  WORD_LEN  load data; valid while done=1, held afterwards
//   done       out  1         one-cycle response pulse
//   stall      out  1         pipeline freeze request
//   err        out  1         bounds error pulse (only with DMEM_BOUNDS_CHECK_EN)
// BEHAVIOUR
//   - Request: req = mem_r_en | mem_w_en. The initiator holds addr/wdata/enables stable while stall=1.
//   - Index: idx = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
//   - FSM states: IDLE, WAIT, RESP. Encoding is free.
//     IDLE: on req, latch addr/wdata/we (we = mem_w_en) and load counter.
//           Go to RESP if LATENCY==1, else go to WAIT.
//     WAIT: decrement counter. Go to RESP so that done asserts exactly LATENCY cycles
//           after the acceptance edge.
//     RESP: done=1 for one cycle, then return to IDLE unconditionally.
//           A req in the next cycle is a new request.
//   - Array access happens on the edge entering RESP.
//     Store: writes mem[idx]; rdata keeps its previous value.
//     Load: rdata <= mem[idx].
//   - stall = req & (state != RESP). This is combinational.
//     The stall cycle count per access is LATENCY, so the pipeline advances on the done cycle.
//   - mem_r_en and mem_w_en both high: treated as a store; rdata is not updated.
//   - Request dropped while in WAIT (pipeline flush): the transaction still completes,
//     and the store is still committed. done pulses; stall is 0 because req=0.
//   - Counter width: 4 bits. No wrap, because the counter reloads on every acceptance.
//   - Reset (rst=0, any state): state=IDLE, counter=0, rdata=0, done=0, err=0.
//     stall then follows req. An in-flight store not yet committed is discarded.
//     Array contents are not reset.
//   - Back-to-back requests: minimum period is LATENCY+1 cycles (one IDLE cycle between them).
// CONFIGURATION
//   DMEM_BOUNDS_CHECK_EN defined:
//     If idx >= DEPTH or addr < BASE_ADDR, the access still takes LATENCY cycles and done pulses.
//     Stores are suppressed, loads return 0, and err pulses together with done.
//   DMEM_BOUNDS_CHECK_EN undefined:
//     idx is truncated to clog2(DEPTH) bits, so the address wraps.
//     err is tied to 0.
// TESTING
//   1. Reset: rst=0 mid-WAIT of a store to 1028 -> done=0, rdata=0, state IDLE;
//      a subsequent load of 1028 returns its old value, not the aborted data.
//   2. Store 0xDEADBEEF to 1028, then load 1028 (LATENCY=2) -> stall high 2 cycles each;
//      done at cycle 2 of each access; load rdata=0xDEADBEEF.
//   3. LATENCY=1, back-to-back loads of 1024 and 1032 -> done on cycles 1 and 3;
//      stall=0 on both done cycles.
//   4. mem_r_en=mem_w_en=1, addr=1036, wdata=5 -> mem[3]=5; rdata unchanged.
//   5. Request dropped in WAIT -> store still committed, done pulses, stall=0.
//   6. With DMEM_BOUNDS_CHECK_EN: load addr=1024+4*DEPTH -> rdata=0, err=1 with done;
//      store to 1020 -> no array change, err=1.
//      Without the macro: store to 1024+4*DEPTH overwrites mem[0].

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned WORD_LEN = 32
);
    logic                mem_r_en;
    logic                mem_w_en;
    logic [WORD_LEN-1:0] addr;
    logic [WORD_LEN-1:0] wdata;
    logic [WORD_LEN-1:0] rdata;
    logic                done;
    logic                stall;
    logic                err;

    modport master (
        output mem_r_en, mem_w_en, addr, wdata,
        input  rdata, done, stall, err
    );

    modport slave (
        input  mem_r_en, mem_w_en, addr, wdata,
        output rdata, done, stall, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage; stalls the pipeline until done.
// Optional bounds checking (suppress/zero out-of-range accesses, pulse err) via DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
    parameter int unsigned WORD_LEN  = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [WORD_LEN-1:0] rdata_q, rdata_d;
    logic [WORD_LEN-1:0] mem_q [DEPTH];

    logic                req;
    logic [WORD_LEN-1:0] offset;
    logic [IdxW-1:0]     idx_live;
    logic                acc_en;
    logic [IdxW-1:0]     acc_idx;
    logic [WORD_LEN-1:0] acc_wdata;
    logic                acc_we;
    logic                acc_ok;
    logic                mem_we;

    assign req      = bus.mem_r_en | bus.mem_w_en;
    assign offset   = bus.addr - WORD_LEN'(BASE_ADDR);
    assign idx_live = IdxW'(offset >> 2);

`ifdef DMEM_BOUNDS_CHECK_EN
    logic oob_q, oob_d;
    logic oob_live;
    logic acc_oob;

    assign oob_live = (bus.addr < WORD_LEN'(BASE_ADDR)) || ((offset >> 2) >= WORD_LEN'(DEPTH));
    assign acc_oob  = (state_q == StIdle) ? oob_live : oob_q;
    assign acc_ok   = ~acc_oob;
    assign oob_d    = ((state_q == StIdle) && req) ? oob_live : oob_q;
`else
    assign acc_ok   = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        // With LATENCY==1 the array is accessed straight from IDLE, before the latch holds it.
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        unique case (state_q)
            StIdle: begin
                acc_idx   = idx_live;
                acc_wdata = bus.wdata;
                acc_we    = bus.mem_w_en;
                if (req) begin
                    idx_d   = idx_live;
                    wdata_d = bus.wdata;
                    we_d    = bus.mem_w_en;
                    cnt_d   = LoadCnt;
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        acc_en  = (state_d == StResp) && (state_q != StResp);
        // Gate with rst so an aborted transaction never commits during reset.
        mem_we  = acc_en & acc_we & acc_ok & rst;
        rdata_d = rdata_q;
        if (acc_en && !acc_we) begin
            rdata_d = acc_ok ? mem_q[acc_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
`ifdef DMEM_BOUNDS_CHECK_EN
            oob_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
`ifdef DMEM_BOUNDS_CHECK_EN
            oob_q   <= oob_d;
`endif
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.done  = (state_q == StResp);
    assign bus.stall = req & (state_q != StResp);
    assign bus.rdata = rdata_q;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign bus.err   = (state_q == StResp) & oob_q;
`else
    assign bus.err   = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance, each checked every
// cycle against a transaction-level model, plus hand-computed literal expectations.
module tb_dmem_responder;
    localparam int unsigned WL    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned BASE  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if #(.WORD_LEN(WL)) bus0 ();
    dmem_responder_if #(.WORD_LEN(WL)) bus1 ();

    dmem_responder #(.WORD_LEN(WL), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    dmem_responder #(.WORD_LEN(WL), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding access per instance, answered lat cycles later.
    int          resp_cyc [2] = '{-1, -1};
    logic [31:0] t_addr   [2];
    logic [31:0] t_wd     [2];
    bit          t_we     [2];
    logic [31:0] m_mem    [2][DEPTH];
    bit          m_known  [2][DEPTH];
    logic [31:0] rd       [2] = '{32'h0, 32'h0};
    bit          rd_known [2] = '{1'b1, 1'b1};

    task automatic model_step(input int d, input int lat, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic e_done, output logic e_stall, output logic e_err);
        logic [31:0] off;
        bit          oob;
        int          idx;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!rst) begin
            resp_cyc[d] = -1;
            rd[d]       = '0;
            rd_known[d] = 1'b1;
            e_stall     = r | w;
            return;
        end
        if (cyc > resp_cyc[d] && (r | w)) begin
            resp_cyc[d] = cyc + lat;
            t_addr[d]   = a;
            t_wd[d]     = wd;
            t_we[d]     = w;
        end
        if (cyc == resp_cyc[d]) begin
            e_done = 1'b1;
            off    = t_addr[d] - BASE;
            oob    = (t_addr[d] < BASE) || ((off / 4) >= DEPTH);
            idx    = int'((off / 4) % DEPTH);
`ifdef DMEM_BOUNDS_CHECK_EN
            if (oob) begin
                e_err = 1'b1;
                if (!t_we[d]) begin
                    rd[d]       = '0;
                    rd_known[d] = 1'b1;
                end
            end else
`endif
            if (t_we[d]) begin
                m_mem[d][idx]   = t_wd[d];
                m_known[d][idx] = 1'b1;
            end else begin
                rd[d]       = m_mem[d][idx];
                rd_known[d] = m_known[d][idx];
            end
            if (oob) t_we[d] = t_we[d];
        end
        e_stall = (r | w) && !e_done;
    endtask

    always @(negedge clk) begin : cmp
        logic ed, es, ee;
        model_step(0, 2, bus0.mem_r_en, bus0.mem_w_en, bus0.addr, bus0.wdata, ed, es, ee);
        check("done0", 32'(bus0.done), 32'(ed));
        check("stall0", 32'(bus0.stall), 32'(es));
        check("err0", 32'(bus0.err), 32'(ee));
        if (rd_known[0]) check("rdata0", bus0.rdata, rd[0]);
        model_step(1, 1, bus1.mem_r_en, bus1.mem_w_en, bus1.addr, bus1.wdata, ed, es, ee);
        check("done1", 32'(bus1.done), 32'(ed));
        check("stall1", 32'(bus1.stall), 32'(es));
        check("err1", 32'(bus1.err), 32'(ee));
        if (rd_known[1]) check("rdata1", bus1.rdata, rd[1]);
    end

    task automatic drive(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            bus0.mem_r_en = r; bus0.mem_w_en = w; bus0.addr = a; bus0.wdata = wd;
        end else begin
            bus1.mem_r_en = r; bus1.mem_w_en = w; bus1.addr = a; bus1.wdata = wd;
        end
    endtask

    // Starts and ends at posedge+1; holds the request for n cycles and records per-cycle outputs.
    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input int n, output logic [7:0] dv,
                          output logic [7:0] sv, output logic [7:0] ev, output logic [31:0] rv);
        dv = '0; sv = '0; ev = '0; rv = '0;
        drive(d, r, w, a, wd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv[i] = (d == 0) ? bus0.done  : bus1.done;
            sv[i] = (d == 0) ? bus0.stall : bus1.stall;
            ev[i] = (d == 0) ? bus0.err   : bus1.err;
            rv    = (d == 0) ? bus0.rdata : bus1.rdata;
            @(posedge clk);
            #1;
        end
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin : stim
        logic [7:0]  dv, sv, ev;
        logic [31:0] rv;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset values
        @(negedge clk);
        check("rst_done", 32'(bus0.done), 32'h0);
        check("rst_stall", 32'(bus0.stall), 32'h0);
        check("rst_rdata", bus0.rdata, 32'h0);
        check("rst_err", 32'(bus0.err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Store then load at LATENCY=2
        access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 3, dv, sv, ev, rv);
        check("st_done_seq", 32'(dv[2:0]), 32'h4);
        check("st_stall_seq", 32'(sv[2:0]), 32'h3);
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 3, dv, sv, ev, rv);
        check("ld_done_seq", 32'(dv[2:0]), 32'h4);
        check("ld_stall_seq", 32'(sv[2:0]), 32'h3);
        check("ld_rdata", rv, 32'hDEADBEEF);

        // Reset during WAIT of a store: the store must be discarded
        drive(0, 1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("abort_done", 32'(bus0.done), 32'h0);
        check("abort_rdata", bus0.rdata, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 3, dv, sv, ev, rv);
        check("abort_old_val", rv, 32'hDEADBEEF);

        // Both enables: store wins, rdata unchanged
        access(0, 1'b1, 1'b1, 32'd1036, 32'd5, 3, dv, sv, ev, rv);
        check("both_rdata", rv, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'd1036, 32'h0, 3, dv, sv, ev, rv);
        check("both_mem3", rv, 32'd5);

        // Request dropped in WAIT: store still committed
        drive(0, 1'b0, 1'b1, 32'd1040, 32'h55);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_done", 32'(bus0.done), 32'h1);
        check("drop_stall", 32'(bus0.stall), 32'h0);
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'd1040, 32'h0, 3, dv, sv, ev, rv);
        check("drop_commit", rv, 32'h55);

        // LATENCY=1 back-to-back loads
        access(1, 1'b0, 1'b1, 32'd1024, 32'h10, 2, dv, sv, ev, rv);
        access(1, 1'b0, 1'b1, 32'd1032, 32'h20, 2, dv, sv, ev, rv);
        access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 2, dv, sv, ev, rv);
        check("l1_a_done", 32'(dv[1:0]), 32'h2);
        check("l1_a_stall", 32'(sv[1:0]), 32'h1);
        check("l1_a_rdata", rv, 32'h10);
        access(1, 1'b1, 1'b0, 32'd1032, 32'h0, 2, dv, sv, ev, rv);
        check("l1_b_done", 32'(dv[1:0]), 32'h2);
        check("l1_b_stall", 32'(sv[1:0]), 32'h1);
        check("l1_b_rdata", rv, 32'h20);

        // Out-of-range addresses
        access(0, 1'b0, 1'b1, 32'd1024, 32'h1234, 3, dv, sv, ev, rv);
`ifdef DMEM_BOUNDS_CHECK_EN
        access(0, 1'b1, 1'b0, BASE + 4 * DEPTH, 32'h0, 3, dv, sv, ev, rv);
        check("oob_ld_rdata", rv, 32'h0);
        check("oob_ld_err", 32'(ev[2:0]), 32'h4);
        access(0, 1'b0, 1'b1, 32'd1020, 32'hBAD, 3, dv, sv, ev, rv);
        check("oob_st_err", 32'(ev[2:0]), 32'h4);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 3, dv, sv, ev, rv);
        check("oob_mem0", rv, 32'h1234);
`else
        access(0, 1'b0, 1'b1, BASE + 4 * DEPTH, 32'hA5A5A5A5, 3, dv, sv, ev, rv);
        check("wrap_err", 32'(ev), 32'h0);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 3, dv, sv, ev, rv);
        check("wrap_mem0", rv, 32'hA5A5A5A5);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
